// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;

    // Operand width the multiplier is built and verified for.
    localparam int unsigned MUL_W = 4;
    // One add/shift step per multiplier bit.
    localparam int unsigned STEPS = MUL_W;
    // Product width.
    localparam int unsigned PW    = 2 * MUL_W;

    // Controller states.
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/add4.sv
// 4-bit ripple-carry adder, purely combinational.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Carry ripples bit by bit from cin to cout.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/mul4_seq.sv
// Sequential unsigned shift-and-add multiplier. One add/shift step per cycle through
// a single ripple-carry adder; the product is presented with a one-cycle done strobe.
module mul4_seq
    import mul_pkg::*;
#(
    parameter int unsigned W = MUL_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  addend;
    logic [W-1:0]  sum;
    logic          cout;

    // Gating the addend with q[0] makes the no-add step yield {0, acc}.
    assign addend = m_q & {W{q_q[0]}};

    add4 u_add4 (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Controller and datapath next-state.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // Right shift of the 2W+1-bit {carry, sum, q}; q[0] drops out.
                {acc_d, q_d} = {cout, sum, q_q[W-1:1]};
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; synchronous reset wins over any start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from registers.
    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign p    = {acc_q, q_q};

endmodule

// File: tb/tb_mul4_seq.sv
// Scoreboard bench for mul4_seq: expected products are queued when a start is driven
// and compared whenever the DUT raises done.
module tb_mul4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int exp_q[$];
    logic prev_done = 1'b0;

    mul4_seq #(.W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every done strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_single_cycle", int'(prev_done), 0);
                done_cnt++;
                if (exp_q.size() == 0) check("unexpected_done", int'(done), 0);
                else check("product", int'(p), exp_q.pop_front());
            end
            prev_done = done;
        end
    end

    // One multiply from idle, scrambling a/b while it runs; checks latency and busy width.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v);
        int lat = 0;
        int bc  = 0;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        exp_q.push_back(int'(ta) * int'(tb_v));
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            if (busy) bc++;
            if (done && lat == 0) lat = i - 1;
            if (!busy) break;
        end
        check("latency", lat, 4);
        check("busy_cycles", bc, 5);
    endtask

    initial begin
        int t0, t1, seen, base, n;
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, seen, base, n;
        // Reset held together with start: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_p", int'(p), 0);
        start = 1'b0;
        rst   = 1'b0;

        // Largest operands.
        run_op(4'd15, 4'd15);

        // Zero operands and a mid-range case.
        run_op(4'd0, 4'd13);
        run_op(4'd9, 4'd0);
        run_op(4'd9, 4'd7);

        // Start held high: a second accept only after returning to idle.
        @(negedge clk);
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        exp_q.push_back(15);
        exp_q.push_back(15);
        seen = 0;
        t0   = 0;
        t1   = 0;
        for (int i = 1; i <= 30 && seen < 2; i++) begin
            @(negedge clk);
            if (done) begin
                if (seen == 0) t0 = i;
                else t1 = i;
                seen++;
            end
        end
        start = 1'b0;
        check("held_accepts", seen, 2);
        check("done_spacing", t1 - t0, 6);
        @(negedge clk);
        check("held_idle_busy", int'(busy), 0);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        a     = 4'd12;
        b     = 4'd11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_p", int'(p), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        #1 base = done_cnt;
        repeat (8) @(negedge clk);
        #1 check("abort_no_done", done_cnt, base);
        run_op(4'd12, 4'd11);

        // Exhaustive, back to back.
        #1 base = done_cnt;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                n = 0;
                while (busy && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 10) check("idle_timeout", int'(busy), 0);
                a     = 4'(ia);
                b     = 4'(ib);
                start = 1'b1;
                exp_q.push_back(ia * ib);
                @(posedge clk);
                #1 start = 1'b0;
                @(negedge clk);
            end
        end
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("exhaustive_done_count", done_cnt - base, 256);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
